cpu_step_ctrl: RTL and testbench
================================

Name: cpu_step_ctrl

Overview:
- Execution-rate controller placed downstream of the board clock divider.
- Produces a single-cycle clock-enable `o_cpu_en` that gates the 5-stage RISC-V pipeline. The block never generates a derived clock.
- Three operating modes:
  - free-run at 1/RUN_DIV of `i_clk`;
  - single-step, one enable per debounced push-button press;
  - halted, entered on a core halt request.

Parameters:
- DEBOUNCE_CYCLES, 20: consecutive stable synchronized samples required before a debounced input changes. Must be ≥1.
- RUN_DIV, 20: in RUN mode, one enable per RUN_DIV cycles. Must be ≥1; a value of 1 gives an enable every cycle.
- CNT_W, 32: width of the saturating step counter.

Ports:
- i_clk  in  1  system clock; single clock domain.
- i_rst_n  in  1  asynchronous active-low reset.
- i_btn_step  in  1  raw push-button, asynchronous, bouncy.
- i_sw_run  in  1  raw run switch, asynchronous, bouncy.
- i_halt  in  1  synchronous halt request from the core (e.g. ebreak retire).
- o_cpu_en  out  1  pipeline clock-enable; a one-cycle pulse.
- o_mode  out  2  current state: 0 PAUSED, 1 STEP, 2 RUN, 3 HALTED.
- o_step_cnt  out  CNT_W  number of enables issued; saturating.

Behaviour:
- Reset is asynchronous, active-low. While `i_rst_n` is low:
  - state = PAUSED, `o_cpu_en` = 0, `o_mode` = 0, `o_step_cnt` = 0;
  - synchronizers, debounced values, debounce counters, edge register and run divider counter all = 0.
  - Reset mid-operation discards any partial debounce or divider count. There is no pending step after reset.
- Input conditioning (identical for button and switch):
  - 2-FF synchronizer produces `s`.
  - Debouncer holds `db` and counter `c`.
  - If `s == db`: `c <= 0`.
  - Else if `c == DEBOUNCE_CYCLES-1`: `db <= s`, `c <= 0`.
  - Otherwise: `c <= c + 1`.
  - Any bounce shorter than DEBOUNCE_CYCLES samples resets `c` and is filtered out.
- Step request: `step_req = btn_db & ~btn_db_q`. It is the rising edge only; releasing the button has no effect.
- FSM (registered state; `o_cpu_en` decoded from registered state and divider):
  - PAUSED → HALTED if `i_halt`; else → RUN if `run_db`; else → STEP if `step_req`; else stay.
  - STEP → HALTED if `i_halt`; else → PAUSED. STEP lasts exactly one cycle.
  - RUN → HALTED if `i_halt`; else → PAUSED if `!run_db`. `step_req` is ignored in RUN.
  - HALTED → HALTED. Only reset exits HALTED.
  - Priority when events coincide: `i_halt` > `run_db` > `step_req`.
- Enable generation:
  - STEP: `o_cpu_en` = 1 for its single cycle, even if `i_halt` is asserted that cycle.
  - RUN: divider `d` counts 0..RUN_DIV-1 and wraps to 0. `o_cpu_en` = (`d == RUN_DIV-1`).
  - `d` is cleared on every entry to RUN, so the first enable arrives RUN_DIV cycles after entry.
  - PAUSED and HALTED: `o_cpu_en` = 0, and `d` is held at 0.
- Latency: if raw `i_btn_step` rises before clock edge 1 and stays stable, `o_cpu_en` is high for exactly the cycle following edge DEBOUNCE_CYCLES+3. With defaults, that is edge 23.
- Step counter:
  - `o_step_cnt` increments on every edge where `o_cpu_en` = 1.
  - It saturates at 2^CNT_W−1 and never wraps.
  - It is not cleared by mode changes.

Decomposition:
- Package `cpu_step_pkg`: holds the state enum typedef (PAUSED/STEP/RUN/HALTED, 2-bit, values as listed under `o_mode`) and the mode encoding constants.
- Sub-module `debouncer`: synchronizer plus debounce counter, parameter DEBOUNCE_CYCLES, output `db`. It is instantiated twice, once for the button and once for the switch.
- The top level contains the edge detect, FSM, divider and counter.

Test Plan:
- Defaults: reset, then hold `i_btn_step` high for 40 cycles and release → exactly one `o_cpu_en` pulse, in the cycle after edge 23. `o_mode` reads 1 for that cycle, then 0. `o_step_cnt` = 1.
- Bounce: toggle `i_btn_step` every 5 cycles for 100 cycles, then hold low → no `o_cpu_en` pulse, `o_step_cnt` = 0.
- Run mode:
  - Set `i_sw_run` high and hold; `o_mode` = 2 once debounced.
  - Enables appear every 20 cycles, the first 20 cycles after entry.
  - Pressing the button during RUN adds no extra pulses.
  - Drop the switch → `o_mode` = 0 after debounce, no further pulses, `o_step_cnt` equals the pulses counted.
- Halt: assert `i_halt` for one cycle in RUN → `o_mode` = 3 on the next cycle and `o_cpu_en` stays 0. Subsequent button presses and switch toggles change nothing until `i_rst_n` pulses low.
- Reset mid-operation: drop `i_rst_n` asynchronously while in RUN with `d` = 10 and a button debounce in progress → all outputs 0 immediately, without waiting for a clock edge. After release: PAUSED, with no spurious pulse.
- Saturation: CNT_W = 4, 20 step presses → `o_step_cnt` reaches 15 and stays at 15, while `o_cpu_en` still pulses for each press.

Source files
------------

// File: rtl/cpu_step_ctrl_pkg.sv
// Shared types for the execution-rate controller: FSM state encoding doubles as
// the externally visible mode value.
package cpu_step_pkg;

  typedef enum logic [1:0] {
    ST_PAUSED = 2'd0,
    ST_STEP   = 2'd1,
    ST_RUN    = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  localparam logic [1:0] MODE_PAUSED = 2'd0;
  localparam logic [1:0] MODE_STEP   = 2'd1;
  localparam logic [1:0] MODE_RUN    = 2'd2;
  localparam logic [1:0] MODE_HALTED = 2'd3;

endpackage

// File: rtl/cpu_step_ctrl_debouncer.sv
// Two-flop synchronizer followed by a counter that only lets the debounced level
// follow the synchronized sample after DEBOUNCE_CYCLES consecutive disagreements.
module debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 20
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic db_o
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          s;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign s = sync_q[1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      db_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      db_q   <= db_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (s != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d = s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign db_o = db_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Execution-rate controller: issues single-cycle pipeline enables in free-run,
// single-step or halted modes and counts them with a saturating counter.
module cpu_step_ctrl
  import cpu_step_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 20,
  parameter int unsigned RUN_DIV         = 20,
  parameter int unsigned CNT_W           = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_btn_step,
  input  logic             i_sw_run,
  input  logic             i_halt,
  output logic             o_cpu_en,
  output logic [1:0]       o_mode,
  output logic [CNT_W-1:0] o_step_cnt
);

  localparam int unsigned DW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(RUN_DIV - 1);

  state_e           state_q, state_d;
  logic             btn_db, run_db;
  logic             btn_db_q;
  logic             step_req;
  logic [DW-1:0]    div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_btn (
    .clk_i  (i_clk),
    .rst_ni (i_rst_n),
    .raw_i  (i_btn_step),
    .db_o   (btn_db)
  );

  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
    .clk_i  (i_clk),
    .rst_ni (i_rst_n),
    .raw_i  (i_sw_run),
    .db_o   (run_db)
  );

  assign step_req = btn_db & ~btn_db_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_PAUSED;
      btn_db_q <= 1'b0;
      div_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      btn_db_q <= btn_db;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_PAUSED: begin
        if (i_halt)        state_d = ST_HALTED;
        else if (run_db)   state_d = ST_RUN;
        else if (step_req) state_d = ST_STEP;
      end
      ST_STEP: state_d = i_halt ? ST_HALTED : ST_PAUSED;
      ST_RUN: begin
        if (i_halt)       state_d = ST_HALTED;
        else if (!run_db) state_d = ST_PAUSED;
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_PAUSED;
    endcase
  end

  assign o_cpu_en = (state_q == ST_STEP) || ((state_q == ST_RUN) && (div_q == DIV_LAST));

  // Divider only advances while staying in RUN, so every RUN entry starts from 0.
  always_comb begin
    div_d = '0;
    if ((state_q == ST_RUN) && (state_d == ST_RUN)) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (o_cpu_en && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign o_mode     = state_q;
  assign o_step_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Bench for cpu_step_ctrl: table-driven scenarios, hand-written corner sequences
// and randomized stimulus, all compared against a cycle-level reference model.
module tb_cpu_step_ctrl;

  localparam int unsigned DB = 20;
  localparam int unsigned RD = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn = 1'b0, run = 1'b0, halt = 1'b0;

  logic        en, en_s;
  logic [1:0]  mode, mode_s;
  logic [31:0] cnt;
  logic [3:0]  cnt_s;

  always #5 clk = ~clk;

  cpu_step_ctrl #(.DEBOUNCE_CYCLES(DB), .RUN_DIV(RD), .CNT_W(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_btn_step(btn), .i_sw_run(run), .i_halt(halt),
    .o_cpu_en(en), .o_mode(mode), .o_step_cnt(cnt)
  );

  cpu_step_ctrl #(.DEBOUNCE_CYCLES(DB), .RUN_DIV(RD), .CNT_W(4)) dut_s (
    .i_clk(clk), .i_rst_n(rst_n), .i_btn_step(btn), .i_sw_run(run), .i_halt(halt),
    .o_cpu_en(en_s), .o_mode(mode_s), .o_step_cnt(cnt_s)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: modes 0..3 as plain integers, RUN timing by age since entry.
  typedef struct packed {
    logic [1:0]  bpipe, rpipe;
    logic        bdb, rdb, bdb_prev;
    int unsigned brun, rrun;
    logic [1:0]  mode;
    int unsigned age;
    logic [31:0] cnt;
    logic [3:0]  cnt_s;
  } mstate_t;

  mstate_t m;

  function automatic logic men(input mstate_t s);
    return (s.mode == 2'd1) || (s.mode == 2'd2 && (s.age % RD) == RD - 1);
  endfunction

  function automatic mstate_t mnext(input mstate_t s, input logic b, input logic r, input logic h);
    mstate_t n = s;
    logic sreq = s.bdb & ~s.bdb_prev;
    n.bpipe = {s.bpipe[0], b};
    n.rpipe = {s.rpipe[0], r};
    n.bdb_prev = s.bdb;
    if (s.bpipe[1] != s.bdb) begin
      if (s.brun + 1 == DB) begin n.bdb = s.bpipe[1]; n.brun = 0; end
      else n.brun = s.brun + 1;
    end else n.brun = 0;
    if (s.rpipe[1] != s.rdb) begin
      if (s.rrun + 1 == DB) begin n.rdb = s.rpipe[1]; n.rrun = 0; end
      else n.rrun = s.rrun + 1;
    end else n.rrun = 0;
    case (s.mode)
      2'd0: n.mode = h ? 2'd3 : s.rdb ? 2'd2 : sreq ? 2'd1 : 2'd0;
      2'd1: n.mode = h ? 2'd3 : 2'd0;
      2'd2: n.mode = h ? 2'd3 : (s.rdb ? 2'd2 : 2'd0);
      default: n.mode = 2'd3;
    endcase
    n.age = (s.mode == 2'd2 && n.mode == 2'd2) ? s.age + 1 : 0;
    if (men(s)) begin
      if (s.cnt != 32'hFFFF_FFFF) n.cnt = s.cnt + 1;
      if (s.cnt_s != 4'hF) n.cnt_s = s.cnt_s + 1;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= mnext(m, btn, run, halt);
  end

  bit chk_en = 1'b0;
  int pulses = 0, pulses_s = 0;

  always @(negedge clk) begin
    if (rst_n && en)   pulses++;
    if (rst_n && en_s) pulses_s++;
    if (chk_en) begin
      chk("model_en", en, men(m));
      chk("model_mode", mode, m.mode);
      chk("model_cnt", cnt, m.cnt);
      chk("model_cnt_s", cnt_s, m.cnt_s);
      chk("model_en_s", en_s, men(m));
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; btn = 1'b0; run = 1'b0; halt = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_mode(input logic [1:0] target, input string name);
    int k = 0;
    while (mode != target && k < 100) begin @(negedge clk); k++; end
    chk({name, "_reached"}, mode, target);
  endtask

  typedef struct {
    int         btn_hold;
    int         run_hold;
    int         exp_pulses;
    logic [1:0] exp_mode;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int p0, c0, expc;

    vecs[0] = '{40, 0, 1, 2'd0};
    vecs[1] = '{19, 0, 0, 2'd0};
    vecs[2] = '{20, 0, 1, 2'd0};
    vecs[3] = '{1, 0, 0, 2'd0};
    vecs[4] = '{0, 100, 5, 2'd0};
    vecs[5] = '{0, 60, 3, 2'd0};
    vecs[6] = '{0, 19, 0, 2'd0};
    vecs[7] = '{30, 100, 5, 2'd0};

    do_reset();
    chk_en = 1'b1;
    chk("reset_en", en, 0);
    chk("reset_mode", mode, 0);
    chk("reset_cnt", cnt, 0);

    // Latency: button rises before edge 1, enable in the cycle after edge 23.
    btn = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      chk($sformatf("lat_en_e%0d", k), en, (k == 23) ? 1 : 0);
      if (k == 23 || k == 24) chk($sformatf("lat_mode_e%0d", k), mode, (k == 23) ? 1 : 0);
    end
    btn = 1'b0;
    repeat (30) @(negedge clk);
    chk("lat_cnt", cnt, 1);

    // Bounce shorter than the debounce window never produces a step.
    do_reset();
    p0 = pulses;
    for (int i = 0; i < 20; i++) begin btn = ~btn; repeat (5) @(negedge clk); end
    btn = 1'b0;
    repeat (40) @(negedge clk);
    chk("bounce_pulses", pulses - p0, 0);
    chk("bounce_cnt", cnt, 0);

    foreach (vecs[i]) begin
      p0 = pulses;
      btn = (vecs[i].btn_hold > 0);
      run = (vecs[i].run_hold > 0);
      for (int c = 0; c < 100; c++) begin
        if (c == vecs[i].btn_hold) btn = 1'b0;
        if (c == vecs[i].run_hold) run = 1'b0;
        @(negedge clk);
      end
      btn = 1'b0; run = 1'b0;
      repeat (60) @(negedge clk);
      chk($sformatf("vec%0d_pulses", i), pulses - p0, vecs[i].exp_pulses);
      chk($sformatf("vec%0d_mode", i), mode, vecs[i].exp_mode);
    end

    // RUN: enable every RD cycles from entry; button presses are ignored.
    c0 = int'(cnt);
    expc = 0;
    run = 1'b1;
    wait_mode(2'd2, "run_entry");
    begin
      int k = 1;
      while (mode == 2'd2 && k < 300) begin
        chk($sformatf("run_en_k%0d", k), en, (k % RD == 0) ? 1 : 0);
        if (k % RD == 0) expc++;
        if (k == 30) btn = 1'b1;
        if (k == 70) btn = 1'b0;
        if (k == 100) run = 1'b0;
        @(negedge clk);
        k++;
      end
      chk("run_exit_bound", (k < 300) ? 1 : 0, 1);
    end
    chk("run_exit_mode", mode, 0);
    repeat (40) @(negedge clk);
    chk("run_cnt", int'(cnt) - c0, expc);

    // Asynchronous reset mid-RUN with a button debounce in flight.
    run = 1'b1;
    wait_mode(2'd2, "rst_run_entry");
    repeat (5) @(negedge clk);
    btn = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_en", en, 0);
    chk("async_mode", mode, 0);
    chk("async_cnt", cnt, 0);
    chk("async_cnt_s", cnt_s, 0);
    btn = 1'b0; run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    p0 = pulses;
    repeat (40) @(negedge clk);
    chk("post_rst_pulses", pulses - p0, 0);
    chk("post_rst_mode", mode, 0);

    // Halt in RUN is sticky until reset.
    run = 1'b1;
    wait_mode(2'd2, "halt_run_entry");
    repeat (7) @(negedge clk);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    chk("halt_mode", mode, 3);
    chk("halt_en", en, 0);
    p0 = pulses;
    run = 1'b0; btn = 1'b1;
    repeat (40) @(negedge clk);
    btn = 1'b0; run = 1'b1;
    repeat (40) @(negedge clk);
    run = 1'b0;
    repeat (30) @(negedge clk);
    chk("halted_pulses", pulses - p0, 0);
    chk("halted_mode", mode, 3);

    // Halt coinciding with STEP: the step enable still fires.
    do_reset();
    btn = 1'b1;
    repeat (23) @(negedge clk);
    chk("stephalt_mode", mode, 1);
    halt = 1'b1;
    chk("stephalt_en", en, 1);
    @(negedge clk);
    halt = 1'b0; btn = 1'b0;
    chk("stephalt_next_mode", mode, 3);
    chk("stephalt_cnt", cnt, 1);

    // Saturation of the 4-bit counter while pulses continue.
    do_reset();
    p0 = pulses_s;
    for (int i = 0; i < 20; i++) begin
      btn = 1'b1; repeat (25) @(negedge clk);
      btn = 1'b0; repeat (25) @(negedge clk);
    end
    chk("sat_pulses", pulses_s - p0, 20);
    chk("sat_cnt_s", cnt_s, 15);
    chk("sat_cnt_wide", cnt, 20);

    // Randomized segments; the per-cycle model comparison does the checking.
    for (int seg = 0; seg < 40; seg++) begin
      do_reset();
      for (int c = 0; c < 150; c++) begin
        if ($urandom_range(0, 29) == 0) btn = ~btn;
        if ($urandom_range(0, 59) == 0) run = ~run;
        halt = ($urandom_range(0, 399) == 0);
        @(negedge clk);
      end
      halt = 1'b0;
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
